vector_tile_buffer: RTL and testbench

- Downstream consumer of the vector load stage (`load_v`).
- Captures each tile pulsed out by the loader (`tile_out` with `data_out[]`) into one of `NUM_BUFFERS` on-chip vector buffers, at consecutive tile slots.
- Closes the transfer on the loader's `valid_out`.
- Provides a 1-cycle-latency read port so compute units can fetch tiles by (buffer, tile index).

---
 rtl/accelerator_config_pkg.sv | 23 ++
 rtl/vector_tile_buffer_storage.sv | 51 +++++
 rtl/vector_tile_buffer.sv | 136 +++++++++++++
 tb/tb_vector_tile_buffer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/accelerator_config_pkg.sv
// Shared accelerator configuration: tile geometry, vector buffer sizing and
// the types used by the vector tile buffer.
package accelerator_config_pkg;

  localparam int TILE_WIDTH   = 256;
  localparam int DATA_WIDTH   = 8;
  localparam int ELEM_COUNT   = TILE_WIDTH / DATA_WIDTH;

  localparam int NUM_VBUFFERS = 4;
  localparam int MAX_VTILES   = 8;
  localparam int VBUF_W       = $clog2(NUM_VBUFFERS);

  typedef logic [VBUF_W-1:0] vbuf_id_t;
  typedef logic [ELEM_COUNT-1:0][DATA_WIDTH-1:0] vtile_t;

  // Write-side sequencing of the vector tile buffer
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITING = 2'd1,
    DONE    = 2'd2
  } vtb_state_t;

endpackage

// File: rtl/vector_tile_buffer_storage.sv
// Tile storage for all vector buffers: one synchronous write port, one
// registered read port returning pre-write contents, cleared on reset.
module tile_storage #(
  parameter int NUM_BUFFERS = 4,
  parameter int MAX_TILES   = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int ELEM_COUNT  = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 wr_en,
  input  logic [$clog2(NUM_BUFFERS)-1:0]       wr_buf,
  input  logic [$clog2(MAX_TILES)-1:0]         wr_idx,
  input  logic [ELEM_COUNT-1:0][DATA_WIDTH-1:0] wr_data,
  input  logic                                 rd_en,
  input  logic [$clog2(NUM_BUFFERS)-1:0]       rd_buf,
  input  logic [$clog2(MAX_TILES)-1:0]         rd_idx,
  output logic [ELEM_COUNT-1:0][DATA_WIDTH-1:0] rd_data
);
  import accelerator_config_pkg::*;

  localparam int DEPTH  = NUM_BUFFERS * MAX_TILES;
  localparam int ADDR_W = $clog2(DEPTH);

  logic [ELEM_COUNT-1:0][DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  assign wr_addr = ADDR_W'(wr_buf) * ADDR_W'(MAX_TILES) + ADDR_W'(wr_idx);
  assign rd_addr = ADDR_W'(rd_buf) * ADDR_W'(MAX_TILES) + ADDR_W'(rd_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read samples the array before this edge's write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/vector_tile_buffer.sv
// Captures loader tiles into consecutive slots of a selected vector buffer
// and serves 1-cycle-latency reads by (buffer, tile index).
module vector_tile_buffer #(
  parameter int TILE_WIDTH  = accelerator_config_pkg::TILE_WIDTH,
  parameter int DATA_WIDTH  = accelerator_config_pkg::DATA_WIDTH,
  parameter int NUM_BUFFERS = 4,
  parameter int MAX_TILES   = 8,
  parameter int ELEM_COUNT  = TILE_WIDTH / DATA_WIDTH,
  parameter int BUF_W       = $clog2(NUM_BUFFERS),
  parameter int IDX_W       = $clog2(MAX_TILES),
  parameter int CNT_W       = $clog2(MAX_TILES + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 wr_start,
  input  logic [BUF_W-1:0]                     wr_buf_id,
  input  logic [ELEM_COUNT-1:0][DATA_WIDTH-1:0] tile_in,
  input  logic                                 tile_valid,
  input  logic                                 last_in,
  output logic                                 wr_busy,
  output logic                                 wr_done,
  output logic                                 overflow,
  input  logic                                 rd_en,
  input  logic [BUF_W-1:0]                     rd_buf_id,
  input  logic [IDX_W-1:0]                     rd_tile_idx,
  output logic [ELEM_COUNT-1:0][DATA_WIDTH-1:0] rd_data,
  output logic                                 rd_valid,
  output logic [CNT_W-1:0]                     rd_tile_count
);
  import accelerator_config_pkg::*;

  vtb_state_t       state;
  vtb_state_t       state_next;
  logic [BUF_W-1:0] cur_buf;
  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] tile_count [NUM_BUFFERS];
  logic             store_tile;
  logic             drop_tile;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    store_tile = 1'b0;
    drop_tile  = 1'b0;
    wr_busy    = 1'b0;
    wr_done    = 1'b0;
    case (state)
      IDLE: begin
        if (wr_start) begin
          state_next = WRITING;
        end
      end
      WRITING: begin
        wr_busy = 1'b1;
        if (tile_valid) begin
          if (wr_ptr < CNT_W'(MAX_TILES)) begin
            store_tile = 1'b1;
          end else begin
            drop_tile = 1'b1;
          end
        end
        if (last_in) begin
          state_next = DONE;
        end
      end
      DONE: begin
        wr_done    = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_buf  <= '0;
      wr_ptr   <= '0;
      overflow <= 1'b0;
      for (int b = 0; b < NUM_BUFFERS; b++) begin
        tile_count[b] <= '0;
      end
    end else begin
      if (state == IDLE && wr_start) begin
        cur_buf               <= wr_buf_id;
        wr_ptr                <= '0;
        overflow              <= 1'b0;
        tile_count[wr_buf_id] <= '0;
      end
      if (store_tile) begin
        wr_ptr              <= wr_ptr + CNT_W'(1);
        tile_count[cur_buf] <= wr_ptr + CNT_W'(1);
      end
      if (drop_tile) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
    end
  end

  assign rd_tile_count = tile_count[rd_buf_id];

  tile_storage #(
    .NUM_BUFFERS (NUM_BUFFERS),
    .MAX_TILES   (MAX_TILES),
    .DATA_WIDTH  (DATA_WIDTH),
    .ELEM_COUNT  (ELEM_COUNT)
  ) u_storage (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (store_tile),
    .wr_buf  (cur_buf),
    .wr_idx  (wr_ptr[IDX_W-1:0]),
    .wr_data (tile_in),
    .rd_en   (rd_en),
    .rd_buf  (rd_buf_id),
    .rd_idx  (rd_tile_idx),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_vector_tile_buffer.sv
// Directed bench for vector_tile_buffer with 256-bit tiles of 8-bit elements.
module tb_vector_tile_buffer;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_start = 1'b0;
  logic [1:0]       wr_buf_id = '0;
  logic [31:0][7:0] tile_in = '0;
  logic             tile_valid = 1'b0;
  logic             last_in = 1'b0;
  logic             wr_busy, wr_done, overflow;
  logic             rd_en = 1'b0;
  logic [1:0]       rd_buf_id = '0;
  logic [2:0]       rd_tile_idx = '0;
  logic [31:0][7:0] rd_data;
  logic             rd_valid;
  logic [3:0]       rd_tile_count;

  int total = 0;
  int bad   = 0;

  vector_tile_buffer #(
    .TILE_WIDTH(256), .DATA_WIDTH(8), .NUM_BUFFERS(4), .MAX_TILES(8)
  ) dut (
    .clk(clk), .rst(rst), .wr_start(wr_start), .wr_buf_id(wr_buf_id),
    .tile_in(tile_in), .tile_valid(tile_valid), .last_in(last_in),
    .wr_busy(wr_busy), .wr_done(wr_done), .overflow(overflow),
    .rd_en(rd_en), .rd_buf_id(rd_buf_id), .rd_tile_idx(rd_tile_idx),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_tile_count(rd_tile_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0][7:0] pat(input logic [7:0] base);
    logic [31:0][7:0] p;
    for (int k = 0; k < 32; k++) p[k] = base + 8'(k);
    return p;
  endfunction

  function automatic logic [31:0][7:0] fill(input logic [7:0] v);
    logic [31:0][7:0] p;
    for (int k = 0; k < 32; k++) p[k] = v;
    return p;
  endfunction

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_start = 0; tile_valid = 0; last_in = 0; rd_en = 0;
  endtask

  task automatic test_reset();
    total++; if (wr_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", wr_busy); end
    total++; if (wr_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", wr_done); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b want=0", rd_valid); end
    total++; if (rd_data !== '0) begin bad++; $display("FAIL reset_rd_data got=%h want=0", rd_data); end
    for (int b = 0; b < 4; b++) begin
      rd_buf_id = 2'(b); #1;
      total++; if (rd_tile_count !== 4'd0) begin bad++; $display("FAIL reset_count%0d got=%0d want=0", b, rd_tile_count); end
    end
  endtask

  task automatic test_normal();
    logic [31:0][7:0] held;
    wr_start = 1; wr_buf_id = 2; tick(); wr_start = 0;
    total++; if (wr_busy !== 1'b1) begin bad++; $display("FAIL normal_busy got=%b want=1", wr_busy); end
    for (int t = 0; t < 3; t++) begin
      tile_valid = 1; tile_in = pat(8'h10 + 8'(t * 16)); last_in = (t == 2);
      tick();
      if (t < 2) begin
        total++; if (wr_done !== 1'b0) begin bad++; $display("FAIL normal_early_done t=%0d got=%b want=0", t, wr_done); end
      end
    end
    idle_inputs();
    total++; if (wr_done !== 1'b1) begin bad++; $display("FAIL normal_done got=%b want=1", wr_done); end
    total++; if (wr_busy !== 1'b0) begin bad++; $display("FAIL normal_busy_done got=%b want=0", wr_busy); end
    tick();
    total++; if (wr_done !== 1'b0) begin bad++; $display("FAIL normal_done_pulse got=%b want=0", wr_done); end
    rd_buf_id = 2; #1;
    total++; if (rd_tile_count !== 4'd3) begin bad++; $display("FAIL normal_count got=%0d want=3", rd_tile_count); end
    for (int t = 0; t < 3; t++) begin
      rd_en = 1; rd_buf_id = 2; rd_tile_idx = 3'(t); tick();
      total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL normal_rd_valid%0d got=%b want=1", t, rd_valid); end
      total++; if (rd_data !== pat(8'h10 + 8'(t * 16))) begin bad++; $display("FAIL normal_rd%0d got=%h want=%h", t, rd_data, pat(8'h10 + 8'(t * 16))); end
    end
    held = pat(8'h30);
    rd_en = 0; rd_tile_idx = 0; tick();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL normal_rd_valid_off got=%b want=0", rd_valid); end
    total++; if (rd_data !== held) begin bad++; $display("FAIL normal_rd_hold got=%h want=%h", rd_data, held); end
  endtask

  task automatic test_overflow();
    wr_start = 1; wr_buf_id = 0; tick(); wr_start = 0;
    for (int t = 0; t < 10; t++) begin
      tile_valid = 1; tile_in = pat(8'h40 + 8'(t * 16)); tick();
      if (t == 7) begin
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_after8 got=%b want=0", overflow); end
      end
      if (t == 8) begin
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_after9 got=%b want=1", overflow); end
      end
    end
    tile_valid = 0; last_in = 1; tick(); idle_inputs(); tick();
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
    rd_buf_id = 0; #1;
    total++; if (rd_tile_count !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d want=8", rd_tile_count); end
    rd_en = 1; rd_tile_idx = 7; tick();
    total++; if (rd_data !== pat(8'hB0)) begin bad++; $display("FAIL ovf_slot7 got=%h want=%h", rd_data, pat(8'hB0)); end
    rd_tile_idx = 0; tick(); rd_en = 0;
    total++; if (rd_data !== pat(8'h40)) begin bad++; $display("FAIL ovf_slot0 got=%h want=%h", rd_data, pat(8'h40)); end
    wr_start = 1; wr_buf_id = 3; tick(); wr_start = 0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", overflow); end
    last_in = 1; tick(); idle_inputs(); tick();
  endtask

  task automatic test_zero_and_ignored();
    tile_valid = 1; last_in = 1; tile_in = pat(8'hEE); tick();
    idle_inputs();
    total++; if (wr_done !== 1'b0 || wr_busy !== 1'b0) begin bad++; $display("FAIL idle_ignore done=%b busy=%b want=0/0", wr_done, wr_busy); end
    tick();
    total++; if (wr_done !== 1'b0) begin bad++; $display("FAIL idle_ignore_done2 got=%b want=0", wr_done); end
    rd_buf_id = 3; #1;
    total++; if (rd_tile_count !== 4'd0) begin bad++; $display("FAIL idle_count got=%0d want=0", rd_tile_count); end
    rd_en = 1; rd_tile_idx = 0; tick(); rd_en = 0;
    total++; if (rd_data !== '0) begin bad++; $display("FAIL idle_no_write got=%h want=0", rd_data); end
    wr_start = 1; wr_buf_id = 3; tick(); wr_start = 0;
    last_in = 1; tick(); last_in = 0;
    total++; if (wr_done !== 1'b1) begin bad++; $display("FAIL zero_done got=%b want=1", wr_done); end
    tick();
    rd_buf_id = 3; #1;
    total++; if (rd_tile_count !== 4'd0) begin bad++; $display("FAIL zero_count got=%0d want=0", rd_tile_count); end
  endtask

  task automatic test_concurrent();
    wr_start = 1; wr_buf_id = 1; tick(); wr_start = 0;
    tile_valid = 1; tile_in = fill(8'hAA); last_in = 1; tick(); idle_inputs(); tick();
    wr_start = 1; wr_buf_id = 1; tick(); wr_start = 0;
    tile_valid = 1; tile_in = fill(8'h55); rd_en = 1; rd_buf_id = 1; rd_tile_idx = 0; tick();
    total++; if (rd_data !== fill(8'hAA)) begin bad++; $display("FAIL rbw_old got=%h want=%h", rd_data, fill(8'hAA)); end
    tile_valid = 0; last_in = 1; tick();
    total++; if (rd_data !== fill(8'h55)) begin bad++; $display("FAIL rbw_new got=%h want=%h", rd_data, fill(8'h55)); end
    idle_inputs(); tick();
  endtask

  task automatic test_busy_start();
    wr_start = 1; wr_buf_id = 1; tick(); wr_start = 0;
    tile_valid = 1; tile_in = pat(8'h11); tick();
    wr_start = 1; wr_buf_id = 3; tile_in = pat(8'h22); tick();
    wr_start = 0; tile_in = pat(8'h33); last_in = 1; tick();
    idle_inputs();
    total++; if (wr_done !== 1'b1) begin bad++; $display("FAIL busy_done got=%b want=1", wr_done); end
    tick();
    rd_buf_id = 1; #1;
    total++; if (rd_tile_count !== 4'd3) begin bad++; $display("FAIL busy_count1 got=%0d want=3", rd_tile_count); end
    rd_buf_id = 3; #1;
    total++; if (rd_tile_count !== 4'd0) begin bad++; $display("FAIL busy_count3 got=%0d want=0", rd_tile_count); end
    rd_en = 1; rd_buf_id = 1; rd_tile_idx = 1; tick(); rd_en = 0;
    total++; if (rd_data !== pat(8'h22)) begin bad++; $display("FAIL busy_slot1 got=%h want=%h", rd_data, pat(8'h22)); end
  endtask

  task automatic test_reset_mid();
    wr_start = 1; wr_buf_id = 2; tick(); wr_start = 0;
    for (int t = 0; t < 2; t++) begin
      tile_valid = 1; tile_in = pat(8'h70 + 8'(t * 16)); tick();
    end
    rst = 1; tile_valid = 0; #1;
    total++; if (wr_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", wr_busy); end
    total++; if (wr_done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b want=0", wr_done); end
    total++; if (rd_data !== '0) begin bad++; $display("FAIL rstmid_rd_data got=%h want=0", rd_data); end
    for (int b = 0; b < 4; b++) begin
      rd_buf_id = 2'(b); #1;
      total++; if (rd_tile_count !== 4'd0) begin bad++; $display("FAIL rstmid_count%0d got=%0d want=0", b, rd_tile_count); end
    end
    tick(); rst = 0; tick();
    total++; if (wr_done !== 1'b0) begin bad++; $display("FAIL rstmid_no_done got=%b want=0", wr_done); end
    wr_start = 1; wr_buf_id = 2; tick(); wr_start = 0;
    for (int t = 0; t < 4; t++) begin
      tile_valid = 1; tile_in = pat(8'h90 + 8'(t * 16)); last_in = (t == 3); tick();
    end
    idle_inputs();
    total++; if (wr_done !== 1'b1) begin bad++; $display("FAIL rstmid_new_done got=%b want=1", wr_done); end
    tick();
    rd_buf_id = 2; #1;
    total++; if (rd_tile_count !== 4'd4) begin bad++; $display("FAIL rstmid_new_count got=%0d want=4", rd_tile_count); end
    rd_en = 1; rd_tile_idx = 3; tick(); rd_en = 0;
    total++; if (rd_data !== pat(8'hC0)) begin bad++; $display("FAIL rstmid_new_slot3 got=%h want=%h", rd_data, pat(8'hC0)); end
  endtask

  initial begin
    #12;
    test_reset();
    tick(); rst = 0; tick();
    test_normal();
    test_overflow();
    test_zero_and_ignored();
    test_concurrent();
    test_busy_start();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
